button_event_gen: RTL and testbench

- Consumes the three debounced button levels and converts them into discrete, queued button events for the game control FSM.
- Event types: press, release and hold-repeat.
- Sits between the debouncer bank and the game logic.
- Delivers events over a valid/ready handshake through a small FIFO, so the game FSM never samples raw levels.

---
 rtl/button_event_gen.sv | 215 +++++++++++++++++++++
 tb/tb_button_event_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// button_event_gen: turns three debounced button levels into queued
// press / release / hold-repeat events. Each channel has a small FSM that
// posts into a one-entry pending slot. A fixed-priority arbiter moves at
// most one slot per cycle into a first-word-fall-through FIFO, which is
// drained over a valid/ready handshake.
module button_event_gen #(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] debounced,
  output logic       evt_valid,
  output logic [1:0] evt_chan,
  output logic [1:0] evt_type,
  input  logic       evt_ready,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_RELEASE = 2'b01;
  localparam logic [1:0] T_REPEAT  = 2'b10;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Edge detection
  logic [2:0]       prev_q;
  logic [2:0]       rise;
  logic [2:0]       fall;

  // Per-channel FSM
  state_t           state_q [3];
  state_t           state_d [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];
  logic [2:0]       post;
  logic [1:0]       post_type [3];

  // Pending slots
  logic [2:0]       pend_vld_q;
  logic [2:0]       pend_vld_d;
  logic [1:0]       pend_type_q [3];
  logic [1:0]       pend_type_d [3];
  logic             ovf_set;
  logic             overflow_q;

  // Arbiter / FIFO
  logic             any_pend;
  logic [1:0]       sel;
  logic [3:0]       push_data;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       head;

  assign rise = debounced & ~prev_q;
  assign fall = ~debounced & prev_q;

  // Per-channel press/hold/repeat FSM; release takes priority over a terminal count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      post[i]      = 1'b0;
      post_type[i] = T_PRESS;
      case (state_q[i])
        S_IDLE: begin
          if (rise[i]) begin
            post[i]      = 1'b1;
            post_type[i] = T_PRESS;
            cnt_d[i]     = '0;
            state_d[i]   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (fall[i]) begin
            post[i]      = 1'b1;
            post_type[i] = T_RELEASE;
            cnt_d[i]     = '0;
            state_d[i]   = S_IDLE;
          end else if (cnt_q[i] == HOLD_LAST) begin
            post[i]      = 1'b1;
            post_type[i] = T_REPEAT;
            cnt_d[i]     = '0;
            state_d[i]   = S_REPEAT;
          end else begin
            cnt_d[i]     = cnt_q[i] + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (fall[i]) begin
            post[i]      = 1'b1;
            post_type[i] = T_RELEASE;
            cnt_d[i]     = '0;
            state_d[i]   = S_IDLE;
          end else if (cnt_q[i] == REP_LAST) begin
            post[i]      = 1'b1;
            post_type[i] = T_REPEAT;
            cnt_d[i]     = '0;
          end else begin
            cnt_d[i]     = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = evt_valid & evt_ready;

  // Fixed-priority arbiter: lowest pending channel wins a FIFO slot.
  always_comb begin
    any_pend  = 1'b0;
    sel       = 2'd0;
    push_data = 4'd0;
    for (int i = 2; i >= 0; i--) begin
      if (pend_vld_q[i]) begin
        any_pend  = 1'b1;
        sel       = 2'(i);
        push_data = {2'(i), pend_type_q[i]};
      end
    end
    push = any_pend & (~full | pop);
  end

  // Slot update: granted slot empties, new posts land; an un-drained slot hit by a post is lost.
  always_comb begin
    pend_vld_d = pend_vld_q;
    ovf_set    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend_type_d[i] = pend_type_q[i];
    end
    if (push) begin
      pend_vld_d[sel] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (post[i]) begin
        if (pend_vld_q[i] && !(push && (sel == 2'(i)))) begin
          ovf_set = 1'b1;
        end
        pend_vld_d[i]  = 1'b1;
        pend_type_d[i] = post_type[i];
      end
    end
  end

  // Control state: edge history, FSMs, slot flags, FIFO pointers, sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      pend_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      prev_q     <= debounced;
      pend_vld_q <= pend_vld_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Payload storage: slot types and FIFO entries, qualified by the control flags.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pend_type_q[i] <= pend_type_d[i];
    end
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_valid = ~empty;
  assign evt_chan  = evt_valid ? head[3:2] : 2'd0;
  assign evt_type  = evt_valid ? head[1:0] : 2'd0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: an event-level model (press age arithmetic,
// slot array, event queue) checked against the DUT on every cycle, plus
// directed scenarios with hand-computed cycle-exact expectations.
module tb_button_event_gen;

  localparam int HOLD  = 8;
  localparam int REP   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] debounced;
  logic       evt_valid;
  logic [1:0] evt_chan;
  logic [1:0] evt_type;
  logic       evt_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_event_gen #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CNT_W        (5),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .debounced(debounced),
    .evt_valid(evt_valid),
    .evt_chan (evt_chan),
    .evt_type (evt_type),
    .evt_ready(evt_ready),
    .overflow (overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [1:0] c;
    logic [1:0] t;
  } ev_t;

  ev_t        mq[$];
  bit         m_held [3];
  bit         m_prv  [3];
  int         m_age  [3];
  bit         m_sv   [3];
  logic [1:0] m_st   [3];
  bit         m_ovf;
  bit         m_pop;
  int         m_g;
  bit         m_post;
  logic [1:0] m_pt;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_held[i] = 1'b0;
        m_prv[i]  = 1'b0;
        m_age[i]  = 0;
        m_sv[i]   = 1'b0;
        m_st[i]   = 2'b00;
      end
    end else begin
      m_pop = (mq.size() > 0) && evt_ready;
      m_g = -1;
      for (int i = 0; i < 3; i++) begin
        if (m_sv[i] && m_g < 0) m_g = i;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_g >= 0 && mq.size() < DEPTH) begin
        mq.push_back(ev_t'{c: 2'(m_g), t: m_st[m_g]});
        m_sv[m_g] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        m_post = 1'b0;
        m_pt   = 2'b00;
        if (!m_held[i] && debounced[i] && !m_prv[i]) begin
          m_post = 1'b1; m_pt = 2'b00; m_held[i] = 1'b1; m_age[i] = 0;
        end else if (m_held[i] && !debounced[i]) begin
          m_post = 1'b1; m_pt = 2'b01; m_held[i] = 1'b0;
        end else if (m_held[i]) begin
          m_age[i]++;
          if (m_age[i] >= HOLD && ((m_age[i] - HOLD) % REP) == 0) begin
            m_post = 1'b1; m_pt = 2'b10;
          end
        end
        if (m_post) begin
          if (m_sv[i]) m_ovf = 1'b1;
          m_sv[i] = 1'b1;
          m_st[i] = m_pt;
        end
        m_prv[i] = debounced[i];
      end
    end
  end

  // Per-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    chk("mdl_valid", int'(evt_valid), int'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("mdl_chan", int'(evt_chan), int'(mq[0].c));
      chk("mdl_type", int'(evt_type), int'(mq[0].t));
    end
    chk("mdl_overflow", int'(overflow), int'(m_ovf));
  end

  // ---------------- directed stimulus ----------------
  int exp_c [5] = '{0, 0, 1, 1, 2};
  int exp_t [5] = '{0, 1, 0, 1, 1};
  int et;

  initial begin
    reset     = 1'b1;
    debounced = 3'b000;
    evt_ready = 1'b1;
    tick(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_chan",  int'(evt_chan),  0);
    chk("rst_type",  int'(evt_type),  0);
    chk("rst_ovf",   int'(overflow),  0);
    reset = 1'b0;

    // Single tap on button 1
    tick(10); debounced[1] = 1'b1;
    tick(2);
    chk("tap_press_valid", int'(evt_valid), 1);
    chk("tap_press_chan",  int'(evt_chan),  1);
    chk("tap_press_type",  int'(evt_type),  0);
    tick(1); debounced[1] = 1'b0;
    chk("tap_gap_valid", int'(evt_valid), 0);
    tick(2);
    chk("tap_rel_valid", int'(evt_valid), 1);
    chk("tap_rel_chan",  int'(evt_chan),  1);
    chk("tap_rel_type",  int'(evt_type),  1);
    tick(1);
    chk("tap_after_valid", int'(evt_valid), 0);
    chk("tap_ovf", int'(overflow), 0);
    tick(5);

    // Hold button 0 for 20 cycles
    tick(10); debounced[0] = 1'b1;
    for (int k = 11; k <= 33; k++) begin
      tick(1);
      chk("hold_valid", int'(evt_valid), int'(k inside {12, 20, 24, 28, 32}));
      if (k inside {12, 20, 24, 28, 32}) begin
        et = (k == 12) ? 0 : ((k == 32) ? 1 : 2);
        chk("hold_chan", int'(evt_chan), 0);
        chk("hold_type", int'(evt_type), et);
      end
      if (k == 30) debounced[0] = 1'b0;
    end
    tick(5);

    // All three buttons rise together
    tick(10); debounced = 3'b111;
    tick(2);
    chk("sim_c0", int'(evt_chan), 0);
    chk("sim_v0", int'(evt_valid), 1);
    tick(1);
    chk("sim_c1", int'(evt_chan), 1);
    chk("sim_v1", int'(evt_valid), 1);
    tick(1);
    chk("sim_c2", int'(evt_chan), 2);
    chk("sim_v2", int'(evt_valid), 1);
    tick(1);
    chk("sim_empty", int'(evt_valid), 0);
    debounced = 3'b000;
    tick(8);

    // Backpressure, then slot overwrite on channel 2
    evt_ready = 1'b0;
    tick(1); debounced[0] = 1'b1;
    tick(2); debounced[0] = 1'b0;
    tick(2); debounced[1] = 1'b1;
    tick(2); debounced[1] = 1'b0;
    tick(2); debounced[2] = 1'b1;
    tick(3);
    chk("bp_head_valid", int'(evt_valid), 1);
    chk("bp_head_chan",  int'(evt_chan),  0);
    chk("bp_head_type",  int'(evt_type),  0);
    chk("bp_ovf_clear",  int'(overflow),  0);
    debounced[2] = 1'b0;
    tick(2);
    chk("bp_ovf_set", int'(overflow), 1);
    evt_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("drain_valid", int'(evt_valid), 1);
      chk("drain_chan",  int'(evt_chan),  exp_c[j]);
      chk("drain_type",  int'(evt_type),  exp_t[j]);
      tick(1);
    end
    chk("drain_empty", int'(evt_valid), 0);
    chk("drain_ovf_sticky", int'(overflow), 1);

    // Reset while button 0 is repeating with three events queued
    evt_ready = 1'b0;
    tick(1); debounced[0] = 1'b1;
    tick(15);
    chk("pre_rst_valid", int'(evt_valid), 1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_ovf",   int'(overflow),  0);
    reset     = 1'b0;
    evt_ready = 1'b1;
    tick(1);
    chk("post_rst_quiet", int'(evt_valid), 0);
    tick(1);
    chk("post_rst_press_valid", int'(evt_valid), 1);
    chk("post_rst_press_chan",  int'(evt_chan),  0);
    chk("post_rst_press_type",  int'(evt_type),  0);
    tick(1);
    chk("post_rst_single", int'(evt_valid), 0);
    debounced[0] = 1'b0;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
